// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

  // Smallest operand width the shift/count datapath supports.
  localparam int WIDTH_MIN = 2;

  // State encodings, kept explicit so waveforms decode predictably.
  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_SHIFT = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    SHIFT = ENC_SHIFT,
    DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder cell (module fa_cell) feeding the serial carry loop.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (p & ci) | (x & y);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, registered carry; SERIAL_ADDER_OVF_EN adds ovf.
// Latency: done_valid rises WIDTH cycles after the start handshake edge.
// Backpressure: result held in DONE until done_ready; start_ready only in IDLE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Reject widths the bit counter and shifters were not built for.
  if (WIDTH < WIDTH_MIN) begin : g_width_check
    $error("serial_adder: WIDTH must be at least %0d", WIDTH_MIN);
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  assign last_bit = (cnt == CNT_LAST);

  fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // State register; async reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; start_ready depends on state only.
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand load on start, then one sum bit per cycle through the cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = carry;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state_q == SHIFT && last_bit) begin
      ovf_r <= carry ^ fa_c;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Latency: checks done_valid arrives WIDTH cycles after start.
// Backpressure: holds done_ready low in DONE and probes start handling.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         done_valid;
  logic         done_ready;
  logic         busy;
  logic         ovf;

  int checks;
  int failures;
  int lat;

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one operation in, then count cycles until done_valid.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, output int n);
    a = ia;
    b = ib;
    cin = icin;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    check("busy_in_shift", 32'(busy), 32'd1);
    check("start_ready_in_shift", 32'(start_ready), 32'd0);
    n = 0;
    while (!done_valid && n < 30) begin
      step();
      n++;
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // 3C + 05 + 0 = 041
    run_op(8'h3C, 8'h05, 1'b0, lat);
    check("basic_latency", 32'(lat), 32'd8);
    check("basic_sum", 32'(sum), 32'h41);
    check("basic_cout", 32'(cout), 32'd0);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    check("basic_exit_start_ready", 32'(start_ready), 32'd1);
    check("basic_exit_done_valid", 32'(done_valid), 32'd0);
    check("basic_exit_busy", 32'(busy), 32'd0);
    check("basic_sum_held", 32'(sum), 32'h41);

    // FF + 01 + 0 = 100, done_ready already high so DONE lasts one cycle
    done_ready = 1'b1;
    run_op(8'hFF, 8'h01, 1'b0, lat);
    check("chain_latency", 32'(lat), 32'd8);
    check("chain_sum", 32'(sum), 32'h00);
    check("chain_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("chain_ovf", 32'(ovf), 32'd0);
`endif
    step();
    check("one_cycle_done_valid", 32'(done_valid), 32'd0);
    check("one_cycle_start_ready", 32'(start_ready), 32'd1);
    done_ready = 1'b0;

    // 00 + 00 + 1 = 001
    run_op(8'h00, 8'h00, 1'b1, lat);
    check("cin_sum", 32'(sum), 32'h01);
    check("cin_cout", 32'(cout), 32'd0);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;

    // 7F + 01 + 0 = 080, signed overflow
    run_op(8'h7F, 8'h01, 1'b0, lat);
    check("ovf_sum", 32'(sum), 32'h80);
    check("ovf_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf_flag", 32'(ovf), 32'd1);
`endif
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;

    // FF + FF + 1 = 1FF, no signed overflow (-1 + -1 + 1)
    run_op(8'hFF, 8'hFF, 1'b1, lat);
    check("max_sum", 32'(sum), 32'hFF);
    check("max_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("max_ovf", 32'(ovf), 32'd0);
`endif
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;

    // Back-pressure: AA + 55 = 0FF held while new starts are offered
    run_op(8'hAA, 8'h55, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      start_valid = i[0] ? 1'b0 : 1'b1;
      a = 8'h11;
      b = 8'h22;
      cin = 1'b1;
      step();
      check("bp_done_valid", 32'(done_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'hFF);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    check("bp_release_start_ready", 32'(start_ready), 32'd1);
    check("bp_release_done_valid", 32'(done_valid), 32'd0);
    check("bp_no_reload_sum", 32'(sum), 32'hFF);
    check("bp_no_reload_cout", 32'(cout), 32'd0);
    step();
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Reset on the 3rd SHIFT cycle
    a = 8'h3C;
    b = 8'h05;
    cin = 1'b1;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done_valid", 32'(done_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'h00);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst_done_valid", 32'(done_valid), 32'd0);
    end
    check("post_rst_start_ready", 32'(start_ready), 32'd1);

    // Block still works after the abort: 12 + 34 + 1 = 047
    run_op(8'h12, 8'h34, 1'b1, lat);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_sum", 32'(sum), 32'h47);
    check("post_rst_cout", 32'(cout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
